decoder_proj: RTL and testbench
===============================

Name: decoder_proj

Overview:
- Registered multi-mode 4-bit decoder driven by a 7-bit packed control/data bus `io_in`.
- Each cycle with enable set, it decodes the 4-bit value per a 2-bit mode: one-hot, thermometer, 7-segment or inverted one-hot.
- Result is registered with a valid flag and parity.
- Sits behind the project's I/O pad bus; also serves as the formal-cover target.

Parameters:
- none (all widths fixed)

Ports:
- clk  input  1  single system clock; all state on rising edge
- rst  input  1  synchronous reset, active-high
- io_in  input  7  packed input bus:
  - [3:0] value d
  - [5:4] mode m
  - [6] enable en
- dec_out  output  16  registered decode result
- valid  output  1  high for one cycle after each load
- parity  output  1  registered XOR-reduction of dec_out
- load_cnt  output  8  number of loads since reset

Behaviour:
- Reset (rst=1 at posedge), all outputs cleared:
  - dec_out=16'h0000
  - valid=0
  - parity=0
  - load_cnt=0
- rst has priority over en.
- Load:
  - If rst=0 and en=1 at posedge, dec_out <= f(m,d), parity <= ^f(m,d), valid <= 1, load_cnt <= load_cnt+1.
  - Latency is exactly 1 cycle from input sample to output.
- Hold:
  - If rst=0 and en=0, dec_out/parity/load_cnt keep their values and valid <= 0.
- Decode function f(m,d):
  - m=00 one-hot: bit d set, others 0 (d=0 -> 16'h0001, d=15 -> 16'h8000).
  - m=01 thermometer: bits [d:0] set (d=0 -> 16'h0001, d=15 -> 16'hFFFF).
  - m=10 7-segment, active-high {g,f,e,d,c,b,a} in [6:0], [15:7]=0. Hex table:
    - 0:3F 1:06 2:5B 3:4F
    - 4:66 5:6D 6:7D 7:07
    - 8:7F 9:6F A:77 b:7C
    - C:39 d:5E E:79 F:71
  - m=11 inverted one-hot: ~(1<<d), e.g. d=0 -> 16'hFFFE.
- load_cnt wraps 255 -> 0 without flag.
- Continuous loads: en held high produces a new result every cycle, and valid stays high.
- Reset mid-stream: the result of the in-flight load is discarded and outputs go to reset values the next cycle.
- Mode/value changes while en=0 have no effect on outputs.
- Purely synchronous; no combinational path from io_in to outputs.

Test Plan:
- Reset then io_in=7'b1101000 (en=1, m=10, d=8) for 1 cycle -> next cycle dec_out=16'h007F, valid=1, parity=1, load_cnt=1; following cycle with en=0 -> valid=0, dec_out holds 16'h007F.
- Sweep m=00 with d=0..15, en=1 -> dec_out=1<<d each cycle, parity=1, valid stays 1, load_cnt increments to 16.
- m=01 d=7 -> 16'h00FF, parity=0; m=11 d=3 -> 16'hFFF7, parity=1; m=10 d=15 -> 16'h0071.
- rst=1 together with en=1 -> all outputs zero next cycle; load_cnt not incremented.
- 256 consecutive loads -> load_cnt wraps to 0; one more load -> 1.
- Change io_in with en=0 across several cycles -> dec_out/parity/load_cnt unchanged, valid=0.

Source files
------------

// File: rtl/decoder_proj.sv
// decoder_proj: registered multi-mode 4-bit decoder (one-hot, thermometer, 7-segment, inverted one-hot)
module decoder_proj (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  io_in,
    output logic [15:0] dec_out,
    output logic        valid,
    output logic        parity,
    output logic [7:0]  load_cnt
);
    logic [3:0]  d;
    logic [1:0]  m;
    logic        en;
    logic [6:0]  seg;
    logic [15:0] f;
    logic [15:0] dec_q, dec_d;
    logic        valid_q, valid_d;
    logic        parity_q, parity_d;
    logic [7:0]  cnt_q, cnt_d;
    assign {en, m, d} = io_in;
    // segment order is {g,f,e,d,c,b,a}
    always_comb begin
        seg = 7'h00;
        case (d)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
    end
    // thermometer: (2<<d)-1 wraps to 16'hFFFF for d=15
    always_comb f = m == 2'd0 ? 16'd1 << d :
                    m == 2'd1 ? (16'd2 << d) - 16'd1 :
                    m == 2'd2 ? {9'd0, seg} : ~(16'd1 << d);
    always_comb begin
        dec_d    = dec_q;
        parity_d = parity_q;
        cnt_d    = cnt_q;
        valid_d  = en;
        if (en) begin
            dec_d    = f;
            parity_d = ^f;
            cnt_d    = cnt_q + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q    <= '0;
            valid_q  <= 1'b0;
            parity_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            dec_q    <= dec_d;
            valid_q  <= valid_d;
            parity_q <= parity_d;
            cnt_q    <= cnt_d;
        end
    end
    assign dec_out  = dec_q;
    assign valid    = valid_q;
    assign parity   = parity_q;
    assign load_cnt = cnt_q;
endmodule

// File: tb/tb_decoder_proj.sv
// tb_decoder_proj: table-driven directed checks plus sweep, 7-segment and wrap sequences
module tb_decoder_proj;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  io_in = 7'd0;
    logic [15:0] dec_out;
    logic        valid, parity;
    logic [7:0]  load_cnt;
    int          total = 0, passed = 0;

    decoder_proj dut (
        .clk(clk), .rst(rst), .io_in(io_in),
        .dec_out(dec_out), .valid(valid), .parity(parity), .load_cnt(load_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [6:0]  io;
        logic [15:0] e_dec;
        logic        e_val;
        logic        e_par;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[13];

    task automatic step(input logic r, input logic [6:0] io);
        @(negedge clk);
        rst   = r;
        io_in = io;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic [15:0] ed, input logic ev,
                           input logic ep, input logic [7:0] ec);
        chk({tag, ".dec"}, dec_out, ed);
        chk({tag, ".valid"}, {15'd0, valid}, {15'd0, ev});
        chk({tag, ".parity"}, {15'd0, parity}, {15'd0, ep});
        chk({tag, ".cnt"}, {8'd0, load_cnt}, {8'd0, ec});
    endtask

    logic [6:0] seg_tab [16];

    initial begin
        vecs[0]  = '{1'b1, 7'b0000000, 16'h0000, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 7'b1101000, 16'h007F, 1'b1, 1'b1, 8'd1};
        vecs[2]  = '{1'b0, 7'b0000000, 16'h007F, 1'b0, 1'b1, 8'd1};
        vecs[3]  = '{1'b0, 7'b1010111, 16'h00FF, 1'b1, 1'b0, 8'd2};
        vecs[4]  = '{1'b0, 7'b1110011, 16'hFFF7, 1'b1, 1'b1, 8'd3};
        vecs[5]  = '{1'b0, 7'b1101111, 16'h0071, 1'b1, 1'b0, 8'd4};
        vecs[6]  = '{1'b0, 7'b1100010, 16'h005B, 1'b1, 1'b1, 8'd5};
        vecs[7]  = '{1'b0, 7'b0111001, 16'h005B, 1'b0, 1'b1, 8'd5};
        vecs[8]  = '{1'b0, 7'b0001110, 16'h005B, 1'b0, 1'b1, 8'd5};
        vecs[9]  = '{1'b1, 7'b1000001, 16'h0000, 1'b0, 1'b0, 8'd0};
        vecs[10] = '{1'b0, 7'b1011111, 16'hFFFF, 1'b1, 1'b0, 8'd1};
        vecs[11] = '{1'b0, 7'b1111111, 16'h7FFF, 1'b1, 1'b1, 8'd2};
        vecs[12] = '{1'b0, 7'b1010000, 16'h0001, 1'b1, 1'b1, 8'd3};
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].r, vecs[i].io);
            chk_all($sformatf("vec%0d", i), vecs[i].e_dec, vecs[i].e_val, vecs[i].e_par, vecs[i].e_cnt);
        end

        // one-hot sweep from reset
        step(1'b1, 7'd0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, {1'b1, 2'b00, 4'(i)});
            chk_all($sformatf("onehot%0d", i), 16'd1 << i, 1'b1, 1'b1, 8'(i + 1));
        end

        // reset while a load is requested discards it
        step(1'b1, 7'b1001010);
        chk_all("rst_en", 16'h0000, 1'b0, 1'b0, 8'd0);

        // full 7-segment table
        for (int i = 0; i < 16; i++) begin
            step(1'b0, {1'b1, 2'b10, 4'(i)});
            chk_all($sformatf("seg%0d", i), {9'd0, seg_tab[i]}, 1'b1, ^seg_tab[i], 8'(i + 1));
        end

        // counter wrap
        step(1'b1, 7'd0);
        for (int i = 0; i < 256; i++) step(1'b0, {1'b1, 2'b11, 4'(i % 16)});
        chk_all("wrap", 16'h7FFF, 1'b1, 1'b1, 8'd0);
        step(1'b0, {1'b1, 2'b00, 4'd5});
        chk_all("wrap1", 16'h0020, 1'b1, 1'b1, 8'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
